// File: rtl/wfg_drive_pat_seq_if.sv
// Pattern word stream between the stream source and the drive pattern sequencer.
// Valid/ready handshake. tready never depends on tvalid.
interface wfg_drive_pat_seq_if #(
  parameter int unsigned CHANNELS = 32
);
  logic [CHANNELS-1:0] tdata;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/wfg_drive_pat_seq.sv
// Buffers stream pattern words and pops one per core sync onto axis_data_o (visible 1 cycle after sync).
// Backpressure: tready drops when the FIFO is full, disabled or idle; empty-FIFO syncs in RUN flag underrun.
module wfg_drive_pat_seq #(
  parameter int unsigned CHANNELS   = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wfg_core_sync_i,
  input  logic                          ctrl_en_q_i,
  input  logic [CHANNELS-1:0]           cfg_mask_q_i,
  wfg_drive_pat_seq_if.slave            wfg_axis,
  output logic [CHANNELS-1:0]           axis_data_o,
  output logic                          active_o,
  output logic                          underrun_o,
  input  logic                          clear_underrun_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic                underrun_q, underrun_d;
  logic [CHANNELS-1:0] mem_q [FIFO_DEPTH];

  logic tready;
  logic push;
  logic pop;
  logic underrun_set;

  assign tready = ctrl_en_q_i && (state_q != S_IDLE) && (level_q < LVL_W'(FIFO_DEPTH));
  assign push   = wfg_axis.tvalid && tready;

  // The pop decision looks at the pre-push level, so a word arriving with the sync is not bypassed.
  assign pop          = ctrl_en_q_i && wfg_core_sync_i && (state_q != S_IDLE) && (level_q != '0);
  assign underrun_set = ctrl_en_q_i && wfg_core_sync_i && (state_q == S_RUN) && (level_q == '0);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    if (!ctrl_en_q_i) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      data_d   = '0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_PRIME;
        S_PRIME: if (pop) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        data_d   = mem_q[rd_ptr_q] & cfg_mask_q_i;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Set has priority over clear; disable leaves the flag alone.
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_set)          underrun_d = 1'b1;
    else if (clear_underrun_i) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wfg_axis.tdata;
  end

  assign wfg_axis.tready = tready;
  assign axis_data_o     = data_q;
  assign active_o        = (state_q == S_RUN);
  assign underrun_o      = underrun_q;
  assign fifo_level_o    = level_q;

endmodule

// File: doc/wfg_drive_pat_seq.md
Name: wfg_drive_pat_seq

Overview:
Sequencer that feeds the per-channel pattern drivers. It buffers AXI-stream pattern words in a small FIFO and presents one new word per waveform-core period on axis_data_o, one bit per channel. Each channel latches its bit at its own cfg_begin subcycle. It also tracks enable sequencing, priming and underrun.

Parameters:
CHANNELS, 32, number of pattern channels (width of one stream word)
FIFO_DEPTH, 4, word buffer depth; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  active-low asynchronous reset
wfg_core_sync_i  input  1  single-cycle pulse at the start of each core period (subcycle 0)
ctrl_en_q_i  input  1  block enable from register file
cfg_mask_q_i  input  CHANNELS  per-channel output mask; 0 forces that channel's bit to 0
wfg_axis_tdata_i  input  CHANNELS  pattern word
wfg_axis_tvalid_i  input  1  stream valid
wfg_axis_tready_o  output  1  stream ready
axis_data_o  output  CHANNELS  current pattern word to channels
active_o  output  1  high while in RUN
underrun_o  output  1  sticky underrun flag
clear_underrun_i  input  1  single-cycle clear of underrun_o
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Single clock; reset is asynchronous, active-low (rst_n).
- Reset values: axis_data_o=0, wfg_axis_tready_o=0, active_o=0, underrun_o=0, fifo_level_o=0. State is IDLE and the FIFO is empty.
- Handshake: a word is pushed in the cycle where tvalid && tready. tready = ctrl_en_q_i && (state!=IDLE) && (level<FIFO_DEPTH), registered-free combinational.
- tready never depends on tvalid. Data is not required to be held once accepted.
- FSM:
  - IDLE: FIFO flushed, axis_data_o=0. Goes to PRIME on the cycle after ctrl_en_q_i is seen high.
  - PRIME: accepts words and ignores sync pulses while the FIFO is empty. Goes to RUN on the first sync with level>=1, and that sync pops.
  - RUN: every sync pops the FIFO head. axis_data_o <= head & cfg_mask_q_i, visible the cycle after the sync.
  - Any state with ctrl_en_q_i low: goes to IDLE next cycle, flushes the FIFO, clears axis_data_o to 0. underrun_o is retained.
- Underrun: a sync in RUN with level==0 holds axis_data_o at its previous value, sets underrun_o and stays in RUN.
  - No bypass: a word pushed in the same cycle as a sync on an empty FIFO is not popped by that sync; it is counted as underrun and consumed at the next sync.
- Simultaneous push and pop with level>=1: both happen and the level is unchanged.
  - At level==FIFO_DEPTH, tready=0, so a pop alone reduces the level.
- Pointers wrap modulo FIFO_DEPTH. Level is a separate counter bounded to 0..FIFO_DEPTH.
- Mask is applied at pop time only. A mask change between syncs does not alter axis_data_o.
- underrun_o clear: clear_underrun_i clears it. If a set and a clear occur in the same cycle, set wins.
- Latency: push at cycle N gives level+1 at N+1. Sync at cycle M gives new axis_data_o at M+1, well before any cfg_begin>=1 subcycle.
- Reset asserted mid-operation returns everything to reset values immediately; the FIFO contents are discarded.

Test Plan:
- Basic flow: enable, push 0xA5A5A5A5 and 0x0F0F0F0F, mask all ones, two syncs -> axis_data_o=0xA5A5A5A5 one cycle after sync 1 and 0x0F0F0F0F after sync 2; active_o=1; underrun_o=0.
- Full backpressure (FIFO_DEPTH=4): push 4 words with no sync -> tready=0 and level=4. Then sync together with tvalid -> level 3, tready returns to 1, the next push brings level back to 4.
- Underrun: RUN with level=0, sync -> axis_data_o holds its last word and underrun_o=1. A sync coinciding with a push on an empty FIFO also sets underrun. clear_underrun_i -> 0. Set and clear in the same cycle -> stays 1.
- Prime: enable with the FIFO empty, three syncs -> state stays PRIME, axis_data_o=0, underrun_o=0. Then push 0x1, sync -> active_o=1 and axis_data_o=0x1.
- Mask: word 0xFFFFFFFF, mask 0x0000FFFF -> 0x0000FFFF. Changing the mask to 0 before the next sync leaves the output unchanged.
- Disable and reset: drop ctrl_en_q_i with level=3 -> next cycle axis_data_o=0, level=0, tready=0, underrun_o retained. Asserting rst_n low mid-RUN clears all outputs asynchronously.
